lsu_arbiter: RTL and testbench

Two-port arbiter and access sequencer that shares the single LSU memory/peripheral port between the core pipeline (port m0) and the debug/loader master (port m1). Accepts one request at a time over valid/ready, drives the LSU for exactly one cycle, captures load data and returns a response over a second valid/ready channel. Uses round-robin priority, and checks alignment and size codes before touching the LSU.

---
 rtl/lsu_arb_pkg.sv | 26 ++
 rtl/lsu_arbiter_rr_arb2.sv | 35 +++
 rtl/lsu_arbiter.sv | 153 +++++++++++++++
 tb/tb_lsu_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types, size codes and command legality check for the LSU arbiter.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  localparam logic [2:0] OP_BYTE = 3'b001;
  localparam logic [2:0] OP_HALF = 3'b011;
  localparam logic [2:0] OP_WORD = 3'b111;

  // A command is legal when its size code is known and the address is naturally aligned.
  function automatic logic op_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      OP_BYTE: ok = 1'b1;
      OP_HALF: ok = ~addr_lo[0];
      OP_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the port that did not win last time wins a tie.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_grant;

  // Pick the requester: on a tie the port other than last_grant, otherwise the only requester.
  always_comb begin
    if (&req) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req[1];
    end
    gnt = '0;
    if (|req) begin
      gnt = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  // Remember the last granted port; reset value 1 lets m0 win the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one LSU port between two masters: arbitrate, run one LSU cycle, return a response.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_valid_i,
  output logic              m0_req_ready_o,
  input  logic [ADDR_W-1:0] m0_req_addr_i,
  input  logic [3:0]        m0_req_op_i,
  input  logic              m0_req_we_i,
  input  logic [DATA_W-1:0] m0_req_wdata_i,
  output logic              m0_rsp_valid_o,
  input  logic              m0_rsp_ready_i,
  output logic [DATA_W-1:0] m0_rsp_rdata_o,
  output logic              m0_rsp_err_o,
  input  logic              m1_req_valid_i,
  output logic              m1_req_ready_o,
  input  logic [ADDR_W-1:0] m1_req_addr_i,
  input  logic [3:0]        m1_req_op_i,
  input  logic              m1_req_we_i,
  input  logic [DATA_W-1:0] m1_req_wdata_i,
  output logic              m1_rsp_valid_o,
  input  logic              m1_rsp_ready_i,
  output logic [DATA_W-1:0] m1_rsp_rdata_o,
  output logic              m1_rsp_err_o,
  output logic [ADDR_W-1:0] lsu_addr_o,
  output logic [3:0]        lsu_ld_op_o,
  output logic [DATA_W-1:0] lsu_st_data_o,
  output logic              lsu_st_en_o,
  input  logic [DATA_W-1:0] lsu_ld_data_i
);

  arb_state_e        state;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              gnt_idx;
  logic              accept;
  logic              in_exec;
  logic              rsp_ready;

  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_op;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_op;
  logic              cmd_we;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_idx;

  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign req    = {m1_req_valid_i, m0_req_valid_i};
  assign accept = (state == IDLE) && (|req);

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req),
    .update  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Route the winning requester's payload toward the command registers.
  always_comb begin
    sel_addr  = gnt_idx ? m1_req_addr_i  : m0_req_addr_i;
    sel_op    = gnt_idx ? m1_req_op_i    : m0_req_op_i;
    sel_we    = gnt_idx ? m1_req_we_i    : m0_req_we_i;
    sel_wdata = gnt_idx ? m1_req_wdata_i : m0_req_wdata_i;
    rsp_ready = cmd_idx ? m1_rsp_ready_i : m0_rsp_ready_i;
  end

  // Sequencer: latch a command, run one LSU cycle (legal only), then hold the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cmd_addr    <= '0;
      cmd_op      <= '0;
      cmd_we      <= 1'b0;
      cmd_wdata   <= '0;
      cmd_idx     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_addr  <= sel_addr;
            cmd_op    <= sel_op;
            cmd_we    <= sel_we;
            cmd_wdata <= sel_wdata;
            cmd_idx   <= gnt_idx;
            if (op_legal(sel_op[2:0], sel_addr[1:0])) begin
              state <= EXEC;
            end else begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        EXEC: begin
          rsp_rdata_q <= cmd_we ? '0 : lsu_ld_data_i;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_exec = (state == EXEC);

  // LSU is driven only during EXEC; reset kills a store in flight combinationally.
  always_comb begin
    lsu_addr_o    = in_exec ? cmd_addr  : '0;
    lsu_ld_op_o   = in_exec ? cmd_op    : '0;
    lsu_st_data_o = in_exec ? cmd_wdata : '0;
    lsu_st_en_o   = in_exec & cmd_we & ~rst_i;
  end

  // Request ready goes to the winner in IDLE; the response appears on the granted port only.
  always_comb begin
    m0_req_ready_o = (state == IDLE) & gnt[0];
    m1_req_ready_o = (state == IDLE) & gnt[1];
    m0_rsp_valid_o = rsp_valid_q & ~cmd_idx;
    m1_rsp_valid_o = rsp_valid_q &  cmd_idx;
    m0_rsp_err_o   = rsp_err_q   & ~cmd_idx;
    m1_rsp_err_o   = rsp_err_q   &  cmd_idx;
    m0_rsp_rdata_o = cmd_idx ? '0 : rsp_rdata_q;
    m1_rsp_rdata_o = cmd_idx ? rsp_rdata_q : '0;
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter with a byte-addressed LSU memory model.
module tb_lsu_arbiter;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk_i;
  logic        rst_i;
  logic        m0_req_valid_i, m1_req_valid_i;
  logic        m0_req_ready_o, m1_req_ready_o;
  logic [31:0] m0_req_addr_i, m1_req_addr_i;
  logic [3:0]  m0_req_op_i, m1_req_op_i;
  logic        m0_req_we_i, m1_req_we_i;
  logic [31:0] m0_req_wdata_i, m1_req_wdata_i;
  logic        m0_rsp_valid_o, m1_rsp_valid_o;
  logic        m0_rsp_ready_i, m1_rsp_ready_i;
  logic [31:0] m0_rsp_rdata_o, m1_rsp_rdata_o;
  logic        m0_rsp_err_o, m1_rsp_err_o;
  logic [31:0] lsu_addr_o;
  logic [3:0]  lsu_ld_op_o;
  logic [31:0] lsu_st_data_o;
  logic        lsu_st_en_o;
  logic [31:0] lsu_ld_data_i;

  logic [7:0]  mem [0:4095];
  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          st_cnt  = 0;

  lsu_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .m0_req_valid_i (m0_req_valid_i),
    .m0_req_ready_o (m0_req_ready_o),
    .m0_req_addr_i  (m0_req_addr_i),
    .m0_req_op_i    (m0_req_op_i),
    .m0_req_we_i    (m0_req_we_i),
    .m0_req_wdata_i (m0_req_wdata_i),
    .m0_rsp_valid_o (m0_rsp_valid_o),
    .m0_rsp_ready_i (m0_rsp_ready_i),
    .m0_rsp_rdata_o (m0_rsp_rdata_o),
    .m0_rsp_err_o   (m0_rsp_err_o),
    .m1_req_valid_i (m1_req_valid_i),
    .m1_req_ready_o (m1_req_ready_o),
    .m1_req_addr_i  (m1_req_addr_i),
    .m1_req_op_i    (m1_req_op_i),
    .m1_req_we_i    (m1_req_we_i),
    .m1_req_wdata_i (m1_req_wdata_i),
    .m1_rsp_valid_o (m1_rsp_valid_o),
    .m1_rsp_ready_i (m1_rsp_ready_i),
    .m1_rsp_rdata_o (m1_rsp_rdata_o),
    .m1_rsp_err_o   (m1_rsp_err_o),
    .lsu_addr_o     (lsu_addr_o),
    .lsu_ld_op_o    (lsu_ld_op_o),
    .lsu_st_data_o  (lsu_st_data_o),
    .lsu_st_en_o    (lsu_st_en_o),
    .lsu_ld_data_i  (lsu_ld_data_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // LSU model: little-endian byte memory, loads extend per op, stores write per size.
  function automatic logic [31:0] lsu_read(input logic [31:0] a, input logic [3:0] op);
    logic [11:0] i;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    i = a[11:0];
    b = mem[i];
    h = {mem[i + 12'd1], mem[i]};
    case (op[2:0])
      3'b001:  r = op[3] ? {{24{b[7]}}, b} : {24'h0, b};
      3'b011:  r = op[3] ? {{16{h[15]}}, h} : {16'h0, h};
      default: r = {mem[i + 12'd3], mem[i + 12'd2], h};
    endcase
    return r;
  endfunction

  assign lsu_ld_data_i = lsu_read(lsu_addr_o, lsu_ld_op_o);

  always @(posedge clk_i) begin
    if (lsu_st_en_o) begin
      mem[lsu_addr_o[11:0]] <= lsu_st_data_o[7:0];
      if (lsu_ld_op_o[1]) mem[lsu_addr_o[11:0] + 12'd1] <= lsu_st_data_o[15:8];
      if (lsu_ld_op_o[2]) begin
        mem[lsu_addr_o[11:0] + 12'd2] <= lsu_st_data_o[23:16];
        mem[lsu_addr_o[11:0] + 12'd3] <= lsu_st_data_o[31:24];
      end
    end
  end

  always @(negedge clk_i) begin
    if (lsu_st_en_o) st_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic check_rsp(input int p, input logic [31:0] rd, input logic err);
    exp_t e;
    if (sb.size() == 0) begin
      chk("rsp_unexpected", 32'(p), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("rsp_port", 32'(p), 32'(e.port));
      chk("rsp_rdata", rd, e.rdata);
      chk1("rsp_err", err, e.err);
    end
  endtask

  // Monitor: every accepted response is matched against the scoreboard head.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m0_rsp_valid_o || m1_rsp_valid_o)
        chk1("rsp_one_port", m0_rsp_valid_o & m1_rsp_valid_o, 1'b0);
      if (m0_rsp_valid_o && m0_rsp_ready_i) check_rsp(0, m0_rsp_rdata_o, m0_rsp_err_o);
      if (m1_rsp_valid_o && m1_rsp_ready_i) check_rsp(1, m1_rsp_rdata_o, m1_rsp_err_o);
    end
  end

  task automatic set_req(input int p, input logic [31:0] a, input logic [3:0] op,
                         input logic we, input logic [31:0] wd);
    if (p == 0) begin
      m0_req_addr_i = a; m0_req_op_i = op; m0_req_we_i = we; m0_req_wdata_i = wd;
    end else begin
      m1_req_addr_i = a; m1_req_op_i = op; m1_req_we_i = we; m1_req_wdata_i = wd;
    end
  endtask

  // Returns one time unit after the handshake edge, i.e. inside the following cycle.
  task automatic issue(input int p, input logic [31:0] a, input logic [3:0] op,
                       input logic we, input logic [31:0] wd);
    logic done;
    done = 1'b0;
    set_req(p, a, op, we, wd);
    if (p == 0) m0_req_valid_i = 1'b1; else m1_req_valid_i = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk_i);
      if ((p == 0) ? m0_req_ready_o : m1_req_ready_o) done = 1'b1;
      @(posedge clk_i);
      #1;
    end
    if (p == 0) m0_req_valid_i = 1'b0; else m1_req_valid_i = 1'b0;
    if (!done) chk1("req_timeout", 1'b0, 1'b1);
  endtask

  // Both payloads must already be set; raises both valids and retires each on its handshake.
  task automatic both_go();
    int c;
    logic r0, r1;
    c = 0;
    m0_req_valid_i = 1'b1;
    m1_req_valid_i = 1'b1;
    while ((m0_req_valid_i || m1_req_valid_i) && c < 100) begin
      @(negedge clk_i);
      c++;
      r0 = m0_req_valid_i & m0_req_ready_o;
      r1 = m1_req_valid_i & m1_req_ready_o;
      if (m0_req_valid_i && m1_req_valid_i)
        chk1("both_ready", m0_req_ready_o & m1_req_ready_o, 1'b0);
      @(posedge clk_i);
      #1;
      if (r0) m0_req_valid_i = 1'b0;
      if (r1) m1_req_valid_i = 1'b0;
    end
    if (c >= 100) begin
      chk1("both_timeout", 1'b0, 1'b1);
      m0_req_valid_i = 1'b0;
      m1_req_valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk_i);
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk1({nm, "_m0_rsp_valid"}, m0_rsp_valid_o, 1'b0);
    chk1({nm, "_m1_rsp_valid"}, m1_rsp_valid_o, 1'b0);
    chk1({nm, "_m0_rsp_err"},   m0_rsp_err_o,   1'b0);
    chk1({nm, "_m1_rsp_err"},   m1_rsp_err_o,   1'b0);
    chk({nm, "_m0_rsp_rdata"},  m0_rsp_rdata_o, 32'h0);
    chk({nm, "_m1_rsp_rdata"},  m1_rsp_rdata_o, 32'h0);
    chk({nm, "_lsu_addr"},      lsu_addr_o,     32'h0);
    chk({nm, "_lsu_ld_op"},     {28'h0, lsu_ld_op_o}, 32'h0);
    chk({nm, "_lsu_st_data"},   lsu_st_data_o,  32'h0);
    chk1({nm, "_lsu_st_en"},    lsu_st_en_o,    1'b0);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst_i = 1'b1;
    m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0;
    m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
    set_req(0, 32'h0, 4'h0, 1'b0, 32'h0);
    set_req(1, 32'h0, 4'h0, 1'b0, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk_idle_outputs("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle_outputs("post_reset");
    chk1("post_reset_m0_ready", m0_req_ready_o, 1'b0);
    @(posedge clk_i);
    #1;

    // Word store then load; EXEC shows one store strobe, response one cycle later.
    c0 = st_cnt;
    sb.push_back('{0, 32'h0, 1'b0});
    issue(0, 32'h010, 4'b0111, 1'b1, 32'hDEADBEEF);
    @(negedge clk_i);
    chk1("exec_st_en", lsu_st_en_o, 1'b1);
    chk("exec_addr", lsu_addr_o, 32'h010);
    chk("exec_st_data", lsu_st_data_o, 32'hDEADBEEF);
    chk1("exec_rsp_valid", m0_rsp_valid_o, 1'b0);
    chk1("exec_req_ready", m0_req_ready_o, 1'b0);
    @(negedge clk_i);
    chk1("legal_rsp_latency", m0_rsp_valid_o, 1'b1);
    drain();
    chk("st_en_one_cycle", 32'(st_cnt - c0), 32'd1);
    sb.push_back('{0, 32'hDEADBEEF, 1'b0});
    issue(0, 32'h010, 4'b0111, 1'b0, 32'h0);
    drain();

    // Byte store and signed/unsigned byte and half loads.
    sb.push_back('{0, 32'h0, 1'b0});
    issue(0, 32'h013, 4'b0001, 1'b1, 32'hAAAAAA80);
    drain();
    sb.push_back('{0, 32'hFFFFFF80, 1'b0});
    issue(0, 32'h013, 4'b1001, 1'b0, 32'h0);
    drain();
    sb.push_back('{0, 32'h00000080, 1'b0});
    issue(0, 32'h013, 4'b0001, 1'b0, 32'h0);
    drain();
    sb.push_back('{0, 32'h000080AD, 1'b0});
    issue(0, 32'h012, 4'b0011, 1'b0, 32'h0);
    drain();
    sb.push_back('{0, 32'hFFFF80AD, 1'b0});
    issue(0, 32'h012, 4'b1011, 1'b0, 32'h0);
    drain();

    // Ties from reset alternate m0, m1, m0, m1.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{0, 32'h80ADBEEF, 1'b0});
      sb.push_back('{1, 32'h0000BEEF, 1'b0});
      set_req(0, 32'h010, 4'b0111, 1'b0, 32'h0);
      set_req(1, 32'h010, 4'b0011, 1'b0, 32'h0);
      both_go();
      drain();
    end
    // After a lone m0 grant, a tie goes to m1.
    sb.push_back('{0, 32'hFFFFFFBE, 1'b0});
    issue(0, 32'h011, 4'b1001, 1'b0, 32'h0);
    drain();
    sb.push_back('{1, 32'h000000AD, 1'b0});
    sb.push_back('{0, 32'hFFFF80AD, 1'b0});
    set_req(0, 32'h012, 4'b1011, 1'b0, 32'h0);
    set_req(1, 32'h012, 4'b0001, 1'b0, 32'h0);
    both_go();
    drain();

    // Illegal commands: immediate error response, LSU untouched.
    c0 = st_cnt;
    sb.push_back('{1, 32'h0, 1'b1});
    issue(1, 32'h012, 4'b0111, 1'b0, 32'h0);
    @(negedge clk_i);
    chk1("illegal_rsp_valid", m1_rsp_valid_o, 1'b1);
    chk1("illegal_rsp_err", m1_rsp_err_o, 1'b1);
    chk("illegal_rsp_rdata", m1_rsp_rdata_o, 32'h0);
    chk1("illegal_st_en", lsu_st_en_o, 1'b0);
    chk("illegal_lsu_addr", lsu_addr_o, 32'h0);
    drain();
    sb.push_back('{1, 32'h0, 1'b1});
    issue(1, 32'h000, 4'b0101, 1'b1, 32'hFFFFFFFF);
    drain();
    sb.push_back('{0, 32'h0, 1'b1});
    issue(0, 32'h011, 4'b0011, 1'b1, 32'h12345678);
    drain();
    chk("illegal_no_store", 32'(st_cnt - c0), 32'd0);
    chk("illegal_mem_intact", lsu_read(32'h010, 4'b0111), 32'h80ADBEEF);

    // Response stall with a pending m1 request, then m1 is served.
    m0_rsp_ready_i = 1'b0;
    sb.push_back('{0, 32'h0, 1'b0});
    issue(0, 32'h880, 4'b0111, 1'b1, 32'h12345678);
    @(posedge clk_i);
    #1;
    set_req(1, 32'h880, 4'b0111, 1'b0, 32'h0);
    m1_req_valid_i = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_i);
      chk1("stall_rsp_valid", m0_rsp_valid_o, 1'b1);
      chk("stall_rsp_rdata", m0_rsp_rdata_o, 32'h0);
      chk1("stall_m0_ready", m0_req_ready_o, 1'b0);
      chk1("stall_m1_ready", m1_req_ready_o, 1'b0);
      @(posedge clk_i);
      #1;
    end
    sb.push_back('{1, 32'h12345678, 1'b0});
    m0_rsp_ready_i = 1'b1;
    issue(1, 32'h880, 4'b0111, 1'b0, 32'h0);
    drain();

    // Reset during EXEC of a store: strobe drops at once, no write, no response.
    issue(0, 32'h884, 4'b0111, 1'b1, 32'hCAFEF00D);
    rst_i = 1'b1;
    #1;
    chk1("rst_exec_st_en", lsu_st_en_o, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk_idle_outputs("rst_exec");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("rst_exec_no_write", lsu_read(32'h884, 4'b0111), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
